// File: rtl/biriscv_vlsu_seq.sv
// Vector unit-stride load/store sequencer: walks vl elements of one vector
// register, issuing one word-aligned memory request per element.
module biriscv_vlsu_seq #(
    parameter int MAX_VL = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_accept_o,
    input  logic [31:0] cmd_opcode_i,
    input  logic [31:0] cmd_base_i,
    input  logic [7:0]  cmd_vl_i,
    input  logic        flush_i,

    output logic        done_o,
    output logic        error_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_data_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,

    output logic [12:0] vrf_raddr_o,
    input  logic [31:0] vrf_rdata_i,
    output logic        vrf_we_o,
    output logic [12:0] vrf_waddr_o,
    output logic [31:0] vrf_wdata_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_VL_C = 8'(MAX_VL);

    // size encoding: 0 = byte, 1 = halfword, 2 = word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_en = 4'b0001 << off;
            2'd1:    byte_en = 4'b0011 << off;
            default: byte_en = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] st_replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    st_replicate = {4{d[7:0]}};
            2'd1:    st_replicate = {2{d[15:0]}};
            default: st_replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] ld_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (size)
            2'd0:    ld_extract = {24'd0, sh[7:0]};
            2'd1:    ld_extract = {16'd0, sh[15:0]};
            default: ld_extract = sh;
        endcase
    endfunction

    state_t      state_q;
    logic        load_q;
    logic [4:0]  vreg_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [7:0]  elem_q;
    logic [7:0]  vl_q;
    logic        err_q;

    logic        dec_load;
    logic        dec_store;
    logic        dec_width_ok;
    logic        dec_legal;
    logic [1:0]  dec_size;
    logic [7:0]  dec_vl;

    logic [31:0] addr_d;
    logic        last_elem;
    logic        in_req;
    logic        ld_write;
    logic        unused_opcode_bits;

    always_comb begin
        dec_size     = 2'd0;
        dec_width_ok = 1'b1;
        case (cmd_opcode_i[14:12])
            3'b000:  dec_size = 2'd0;
            3'b101:  dec_size = 2'd1;
            3'b110:  dec_size = 2'd2;
            default: dec_width_ok = 1'b0;
        endcase
    end

    assign dec_load  = (cmd_opcode_i[6:0] == 7'b0000111);
    assign dec_store = (cmd_opcode_i[6:0] == 7'b0100111);
    assign dec_legal = (dec_load | dec_store) & dec_width_ok & (cmd_opcode_i[27:26] == 2'b00);
    assign dec_vl    = (cmd_vl_i > MAX_VL_C) ? MAX_VL_C : cmd_vl_i;

    assign unused_opcode_bits = ^{cmd_opcode_i[31:28], cmd_opcode_i[25:15]};

    assign addr_d    = addr_q + (32'd1 << size_q);
    assign last_elem = (elem_q == (vl_q - 8'd1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            vreg_q  <= 5'd0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            elem_q  <= 8'd0;
            vl_q    <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_accept_o) begin
                        load_q <= dec_load;
                        vreg_q <= cmd_opcode_i[11:7];
                        size_q <= dec_size;
                        addr_q <= cmd_base_i;
                        elem_q <= 8'd0;
                        vl_q   <= dec_vl;
                        if (!dec_legal) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (dec_vl == 8'd0) begin
                            err_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else if (misaligned(dec_size, cmd_base_i[1:0])) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // an accepted-then-flushed request still owes us an ack
                    if (flush_i) begin
                        state_q <= mem_accept_i ? ST_DRAIN : ST_IDLE;
                    end else if (mem_accept_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        state_q <= mem_ack_i ? ST_IDLE : ST_DRAIN;
                    end else if (mem_ack_i) begin
                        if (mem_error_i) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (last_elem) begin
                            err_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            elem_q <= elem_q + 8'd1;
                            addr_q <= addr_d;
                            if (misaligned(size_q, addr_d[1:0])) begin
                                err_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_REQ;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_req   = (state_q == ST_REQ);
    assign ld_write = (state_q == ST_WAIT) && mem_ack_i && !mem_error_i && !flush_i && load_q;

    assign cmd_accept_o = (state_q == ST_IDLE) && !flush_i;
    assign done_o       = (state_q == ST_DONE) && !flush_i;
    assign error_o      = done_o && err_q;

    assign mem_addr_o    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_rd_o      = in_req && load_q;
    assign mem_wr_o      = (in_req && !load_q) ? byte_en(size_q, addr_q[1:0]) : 4'd0;
    assign mem_data_wr_o = (in_req && !load_q) ? st_replicate(size_q, vrf_rdata_i) : 32'd0;
    assign vrf_raddr_o   = (in_req && !load_q) ? {vreg_q, elem_q} : 13'd0;

    assign vrf_we_o    = ld_write;
    assign vrf_waddr_o = ld_write ? {vreg_q, elem_q} : 13'd0;
    assign vrf_wdata_o = ld_write ? ld_extract(size_q, addr_q[1:0], mem_data_rd_i) : 32'd0;

endmodule

// File: tb/tb_biriscv_vlsu_seq.sv
// Directed bench for biriscv_vlsu_seq: a vector table with a byte-addressed
// memory model, plus hand-written flush/reset/stall sequences.
module tb_biriscv_vlsu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_accept_o;
    logic [31:0] cmd_opcode_i = 32'd0;
    logic [31:0] cmd_base_i = 32'd0;
    logic [7:0]  cmd_vl_i = 8'd0;
    logic        flush_i = 1'b0;
    logic        done_o;
    logic        error_o;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [31:0] mem_data_wr_o;
    logic        mem_accept_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic        mem_error_i = 1'b0;
    logic [31:0] mem_data_rd_i = 32'd0;
    logic [12:0] vrf_raddr_o;
    logic [31:0] vrf_rdata_i = 32'd0;
    logic        vrf_we_o;
    logic [12:0] vrf_waddr_o;
    logic [31:0] vrf_wdata_o;

    int checks = 0;
    int failures = 0;

    biriscv_vlsu_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_accept_o (cmd_accept_o),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_base_i   (cmd_base_i),
        .cmd_vl_i     (cmd_vl_i),
        .flush_i      (flush_i),
        .done_o       (done_o),
        .error_o      (error_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_wr_o     (mem_wr_o),
        .mem_data_wr_o(mem_data_wr_o),
        .mem_accept_i (mem_accept_i),
        .mem_ack_i    (mem_ack_i),
        .mem_error_i  (mem_error_i),
        .mem_data_rd_i(mem_data_rd_i),
        .vrf_raddr_o  (vrf_raddr_o),
        .vrf_rdata_i  (vrf_rdata_i),
        .vrf_we_o     (vrf_we_o),
        .vrf_waddr_o  (vrf_waddr_o),
        .vrf_wdata_o  (vrf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] op;
        logic [31:0] base;
        logic [7:0]  vl;
        int          err_ack;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] al;
        logic [15:0] be;
        int          nwr;
        logic [31:0] data;
        logic [12:0] wa;
        int          done_cyc;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    // each memory byte holds the low byte of its own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [31:0] vrf_val(input logic [12:0] r);
        return 32'hA5C3_0000 | {19'd0, r};
    endfunction

    function automatic logic [31:0] mk_op(input logic ld, input logic [4:0] vr,
                                          input logic [2:0] w, input logic [1:0] mop);
        return {4'b0, mop, 11'b0, w, vr, (ld ? 7'b0000111 : 7'b0100111)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_cmd(input logic [31:0] op, input logic [31:0] base, input logic [7:0] vl);
        cmd_opcode_i = op;
        cmd_base_i   = base;
        cmd_vl_i     = vl;
    endtask

    task automatic drv(input logic cv, input logic fl, input logic acc, input logic ack,
                       input logic [31:0] rd);
        @(negedge clk_i);
        cmd_valid_i   = cv;
        flush_i       = fl;
        mem_accept_i  = acc;
        mem_ack_i     = ack;
        mem_error_i   = 1'b0;
        mem_data_rd_i = rd;
        #1;
        vrf_rdata_i = vrf_val(vrf_raddr_o);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          nreq, nwr, done_cyc, ack_idx;
        logic        err_seen, pend;
        logic [31:0] a_first, a_last, d_last, pend_addr;
        logic [15:0] be_hist;
        logic [12:0] wa_last;
        nreq = 0; nwr = 0; done_cyc = -1; ack_idx = 0;
        err_seen = 1'b0; pend = 1'b0;
        a_first = 32'd0; a_last = 32'd0; d_last = 32'd0; pend_addr = 32'd0;
        be_hist = 16'd0; wa_last = 13'd0;
        set_cmd(v.op, v.base, v.vl);
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(negedge clk_i);
            cmd_valid_i   = (cyc == 0);
            flush_i       = 1'b0;
            mem_ack_i     = pend;
            mem_error_i   = pend && (ack_idx == v.err_ack);
            mem_data_rd_i = pend ? mem_word(pend_addr) : 32'd0;
            #1;
            vrf_rdata_i  = vrf_val(vrf_raddr_o);
            mem_accept_i = mem_rd_o | (|mem_wr_o);
            #1;
            if (cyc == 0) chk($sformatf("v%0d_accept", idx), {31'd0, cmd_accept_o}, 32'd1);
            if (mem_accept_i) begin
                if (nreq == 0) a_first = mem_addr_o;
                a_last = mem_addr_o;
                if (nreq < 4) be_hist[nreq*4 +: 4] = mem_wr_o;
                if (!mem_rd_o) d_last = mem_data_wr_o;
                pend_addr = mem_addr_o;
                nreq++;
            end
            if (vrf_we_o) begin
                nwr++;
                d_last  = vrf_wdata_o;
                wa_last = vrf_waddr_o;
            end
            if (done_o) begin
                done_cyc = cyc;
                err_seen = error_o;
            end
            if (mem_ack_i) ack_idx++;
            pend = mem_accept_i;
        end
        cmd_valid_i = 1'b0; mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0;
        chk($sformatf("v%0d_nreq", idx), 32'(nreq), 32'(v.nreq));
        chk($sformatf("v%0d_addr_first", idx), a_first, v.a0);
        chk($sformatf("v%0d_addr_last", idx), a_last, v.al);
        chk($sformatf("v%0d_byte_en", idx), {16'd0, be_hist}, {16'd0, v.be});
        chk($sformatf("v%0d_nwrites", idx), 32'(nwr), 32'(v.nwr));
        chk($sformatf("v%0d_data_last", idx), d_last, v.data);
        chk($sformatf("v%0d_waddr_last", idx), {19'd0, wa_last}, {19'd0, v.wa});
        chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.done_cyc));
        chk($sformatf("v%0d_error", idx), {31'd0, err_seen}, {31'd0, v.err});
    endtask

    initial begin
        //          op                      base          vl    eack nreq a0            al            be        nwr data          wa      done err
        vecs[0]  = '{mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd4,  -1, 4,  32'h0000_1000, 32'h0000_100C, 16'h0000, 4,  32'h0F0E_0D0C, 13'h203, 9,  1'b0};
        vecs[1]  = '{mk_op(0,3,3'b000,0), 32'h0000_2003, 8'd3,  -1, 3,  32'h0000_2000, 32'h0000_2004, 16'h0218, 0,  32'h0202_0202, 13'h000, 7,  1'b0};
        vecs[2]  = '{mk_op(1,2,3'b101,0), 32'h0000_3001, 8'd4,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b1};
        vecs[3]  = '{mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd4,  1,  2,  32'h0000_1000, 32'h0000_1004, 16'h0000, 1,  32'h0302_0100, 13'h200, 5,  1'b1};
        vecs[4]  = '{mk_op(1,2,3'b110,0), 32'hFFFF_FFFC, 8'd2,  -1, 2,  32'hFFFF_FFFC, 32'h0000_0000, 16'h0000, 2,  32'h0302_0100, 13'h201, 5,  1'b0};
        vecs[5]  = '{mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd0,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b0};
        vecs[6]  = '{32'h0000_6103,        32'h0000_1000, 8'd2,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b1};
        vecs[7]  = '{mk_op(1,2,3'b110,1), 32'h0000_1000, 8'd2,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b1};
        vecs[8]  = '{mk_op(1,2,3'b111,0), 32'h0000_1000, 8'd2,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b1};
        vecs[9]  = '{mk_op(1,2,3'b000,0), 32'h0000_4001, 8'd3,  -1, 3,  32'h0000_4000, 32'h0000_4000, 16'h0000, 3,  32'h0000_0003, 13'h202, 7,  1'b0};
        vecs[10] = '{mk_op(1,2,3'b101,0), 32'h0000_5002, 8'd2,  -1, 2,  32'h0000_5000, 32'h0000_5004, 16'h0000, 2,  32'h0000_0504, 13'h201, 5,  1'b0};
        vecs[11] = '{mk_op(0,4,3'b110,0), 32'h0000_6000, 8'd2,  -1, 2,  32'h0000_6000, 32'h0000_6004, 16'h00FF, 0,  32'hA5C3_0401, 13'h000, 5,  1'b0};
        vecs[12] = '{mk_op(0,6,3'b101,0), 32'h0000_7002, 8'd2,  -1, 2,  32'h0000_7000, 32'h0000_7004, 16'h003C, 0,  32'h0601_0601, 13'h000, 5,  1'b0};
        vecs[13] = '{mk_op(1,2,3'b110,0), 32'h0000_8000, 8'd40, -1, 32, 32'h0000_8000, 32'h0000_807C, 16'h0000, 32, 32'h7F7E_7D7C, 13'h21F, 65, 1'b0};
        vecs[14] = '{mk_op(1,2,3'b110,0), 32'h0000_9002, 8'd2,  -1, 0,  32'h0,         32'h0,         16'h0000, 0,  32'h0,         13'h000, 1,  1'b1};

        // reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_accept", {31'd0, cmd_accept_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_mem_wr", {28'd0, mem_wr_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_vrf_we", {31'd0, vrf_we_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // flush in WAIT of element 1: drain the ack, no write, no done
        set_cmd(mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd4);
        drv(1, 0, 0, 0, 32'd0);
        chk("fw_accept", {31'd0, cmd_accept_o}, 32'd1);
        drv(0, 0, 1, 0, 32'd0);
        chk("fw_req0_addr", mem_addr_o, 32'h0000_1000);
        drv(0, 0, 0, 1, mem_word(32'h0000_1000));
        chk("fw_we0", {31'd0, vrf_we_o}, 32'd1);
        drv(0, 0, 1, 0, 32'd0);
        chk("fw_req1_addr", mem_addr_o, 32'h0000_1004);
        drv(0, 1, 0, 0, 32'd0);
        chk("fw_flush_we", {31'd0, vrf_we_o}, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fw_drain_accept", {31'd0, cmd_accept_o}, 32'd0);
        chk("fw_drain_rd", {31'd0, mem_rd_o}, 32'd0);
        drv(0, 0, 0, 1, mem_word(32'h0000_1004));
        chk("fw_drain_ack_we", {31'd0, vrf_we_o}, 32'd0);
        chk("fw_drain_ack_done", {31'd0, done_o}, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fw_idle_accept", {31'd0, cmd_accept_o}, 32'd1);
        chk("fw_idle_done", {31'd0, done_o}, 32'd0);

        // flush with accept in the same REQ cycle -> DRAIN
        set_cmd(mk_op(0,4,3'b110,0), 32'h0000_6000, 8'd2);
        drv(1, 0, 0, 0, 32'd0);
        drv(0, 1, 1, 0, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fra_drain_accept", {31'd0, cmd_accept_o}, 32'd0);
        chk("fra_drain_wr", {28'd0, mem_wr_o}, 32'd0);
        drv(0, 0, 0, 1, 32'd0);
        chk("fra_ack_done", {31'd0, done_o}, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fra_idle_accept", {31'd0, cmd_accept_o}, 32'd1);

        // flush in REQ without accept -> straight to IDLE
        set_cmd(mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd2);
        drv(1, 0, 0, 0, 32'd0);
        drv(0, 1, 0, 0, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fr_idle_accept", {31'd0, cmd_accept_o}, 32'd1);
        chk("fr_idle_rd", {31'd0, mem_rd_o}, 32'd0);

        // flush in DONE suppresses the pulse
        set_cmd(32'h0000_6103, 32'h0000_1000, 8'd2);
        drv(1, 0, 0, 0, 32'd0);
        drv(0, 1, 0, 0, 32'd0);
        chk("fd_done", {31'd0, done_o}, 32'd0);
        chk("fd_error", {31'd0, error_o}, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("fd_after_done", {31'd0, done_o}, 32'd0);
        chk("fd_after_accept", {31'd0, cmd_accept_o}, 32'd1);

        // request held stable while memory stalls
        set_cmd(mk_op(1,2,3'b110,0), 32'h1234_5670, 8'd1);
        drv(1, 0, 0, 0, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("stall_rd", {31'd0, mem_rd_o}, 32'd1);
        chk("stall_addr", mem_addr_o, 32'h1234_5670);
        drv(0, 0, 1, 0, 32'd0);
        drv(0, 0, 0, 1, mem_word(32'h1234_5670));
        chk("stall_wdata", vrf_wdata_o, 32'h7372_7170);
        chk("stall_waddr", {19'd0, vrf_waddr_o}, 32'h0000_0200);
        drv(0, 0, 0, 0, 32'd0);
        chk("stall_done", {31'd0, done_o}, 32'd1);
        chk("stall_error", {31'd0, error_o}, 32'd0);

        // reset mid-command: abandon it and ignore the stale ack
        set_cmd(mk_op(1,2,3'b110,0), 32'h0000_1000, 8'd4);
        drv(1, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 0, 32'd0);
        @(negedge clk_i);
        mem_accept_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mrst_accept", {31'd0, cmd_accept_o}, 32'd1);
        chk("mrst_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("mrst_addr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_ack_i = 1'b1;
        mem_data_rd_i = mem_word(32'h0000_1000);
        #2;
        chk("mrst_ack_we", {31'd0, vrf_we_o}, 32'd0);
        chk("mrst_ack_done", {31'd0, done_o}, 32'd0);
        drv(0, 0, 0, 0, 32'd0);
        chk("mrst_after_done", {31'd0, done_o}, 32'd0);
        chk("mrst_after_accept", {31'd0, cmd_accept_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
